// File: rtl/ps2_snes_pkg.sv
// rtl/ps2_snes_pkg.sv - shared types, scan-code constants and key map tables for the PS/2-to-SNES mapper
package ps2_snes_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BRK     = 2'd1,
        ST_EXT     = 2'd2,
        ST_EXT_BRK = 2'd3
    } prefix_state_e;

    localparam logic [7:0] SC_BREAK   = 8'hF0;
    localparam logic [7:0] SC_EXT     = 8'hE0;
    localparam logic [7:0] SC_OVERRUN = 8'h00;
    localparam logic [7:0] SC_ERROR   = 8'hFF;
    localparam logic [7:0] SC_BAT_OK  = 8'hAA;

    localparam logic [3:0] BIT_B      = 4'd15;
    localparam logic [3:0] BIT_Y      = 4'd14;
    localparam logic [3:0] BIT_SELECT = 4'd13;
    localparam logic [3:0] BIT_START  = 4'd12;
    localparam logic [3:0] BIT_UP     = 4'd11;
    localparam logic [3:0] BIT_DOWN   = 4'd10;
    localparam logic [3:0] BIT_LEFT   = 4'd9;
    localparam logic [3:0] BIT_RIGHT  = 4'd8;
    localparam logic [3:0] BIT_A      = 4'd7;
    localparam logic [3:0] BIT_X      = 4'd6;
    localparam logic [3:0] BIT_L      = 4'd5;
    localparam logic [3:0] BIT_R      = 4'd4;

    typedef struct packed {
        logic [7:0] code;
        logic [3:0] idx;
    } map_entry_t;

    localparam int STD_MAP_LEN = 12;
    localparam int EXT_MAP_LEN = 4;

    localparam map_entry_t STD_MAP [STD_MAP_LEN] = '{
        '{8'h2D, BIT_B},      '{8'h35, BIT_Y},     '{8'h2B, BIT_SELECT},
        '{8'h2C, BIT_START},  '{8'h1D, BIT_UP},    '{8'h1B, BIT_DOWN},
        '{8'h1C, BIT_LEFT},   '{8'h23, BIT_RIGHT}, '{8'h24, BIT_A},
        '{8'h34, BIT_X},      '{8'h15, BIT_L},     '{8'h3C, BIT_R}
    };

    localparam map_entry_t EXT_MAP [EXT_MAP_LEN] = '{
        '{8'h75, BIT_UP}, '{8'h72, BIT_DOWN}, '{8'h6B, BIT_LEFT}, '{8'h74, BIT_RIGHT}
    };

    function automatic logic is_release_all(input logic [7:0] c);
        return (c == SC_OVERRUN) || (c == SC_ERROR) || (c == SC_BAT_OK);
    endfunction

    function automatic logic [7:0] bit_reverse8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

endpackage

// File: rtl/ps2_prefix_fsm.sv
// rtl/ps2_prefix_fsm.sv - F0/E0 prefix tracker with timeout; extended prefix only with PS2_EXT_KEYS_EN
module ps2_prefix_fsm
    import ps2_snes_pkg::*;
#(
    parameter int BIT_REVERSE    = 1,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       byte_valid_i,
    input  logic [7:0] key_byte_i,
    output logic       make_o,
    output logic       break_o,
    output logic       ext_o,
    output logic       release_o,
    output logic [7:0] code_o
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);

    prefix_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    code;

    assign code   = (BIT_REVERSE != 0) ? bit_reverse8(key_byte_i) : key_byte_i;
    assign code_o = code;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        make_o    = 1'b0;
        break_o   = 1'b0;
        ext_o     = 1'b0;
        release_o = 1'b0;
        if (byte_valid_i) begin
            // An arriving byte always beats a coincident timeout.
            cnt_d = '0;
            if (is_release_all(code)) begin
                release_o = 1'b1;
                state_d   = ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (code == SC_BREAK) begin
                            state_d = ST_BRK;
`ifdef PS2_EXT_KEYS_EN
                        end else if (code == SC_EXT) begin
                            state_d = ST_EXT;
`endif
                        end else begin
                            make_o = 1'b1;
                        end
                    end
                    ST_BRK: begin
                        break_o = 1'b1;
                        state_d = ST_IDLE;
                    end
`ifdef PS2_EXT_KEYS_EN
                    ST_EXT: begin
                        if (code == SC_BREAK) begin
                            state_d = ST_EXT_BRK;
                        end else begin
                            make_o  = 1'b1;
                            ext_o   = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end
                    ST_EXT_BRK: begin
                        break_o = 1'b1;
                        ext_o   = 1'b1;
                        state_d = ST_IDLE;
                    end
`endif
                    default: state_d = ST_IDLE;
                endcase
            end
        end else if (state_q != ST_IDLE) begin
            if (cnt_q == CNT_MAX) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_snes_key_mapper.sv
// rtl/ps2_snes_key_mapper.sv - PS/2 scan codes to registered active-low SNES button word; PS2_EXT_KEYS_EN adds E0 arrows
module ps2_snes_key_mapper
    import ps2_snes_pkg::*;
#(
    parameter int   BIT_REVERSE    = 1,
    parameter int   TIMEOUT_CYCLES = 50000,
    parameter logic UNUSED_LEVEL   = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        byte_valid,
    input  logic [7:0]  key_byte,
    output logic [15:0] buttons_n,
    output logic        update,
    output logic        unknown_key
);

    localparam logic [15:0] BTN_RESET = {12'hFFF, {4{UNUSED_LEVEL}}};

    logic        ev_make, ev_break, ev_ext, ev_release;
    logic [7:0]  ev_code;
    logic        hit;
    logic [3:0]  idx;
    logic [15:0] btn_q, btn_d;
    logic        upd_q, upd_d;
    logic        unk_q, unk_d;

    ps2_prefix_fsm #(
        .BIT_REVERSE    (BIT_REVERSE),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_fsm (
        .clk          (clk),
        .rst          (reset),
        .byte_valid_i (byte_valid),
        .key_byte_i   (key_byte),
        .make_o       (ev_make),
        .break_o      (ev_break),
        .ext_o        (ev_ext),
        .release_o    (ev_release),
        .code_o       (ev_code)
    );

    always_comb begin
        hit = 1'b0;
        idx = 4'd0;
        if (ev_ext) begin
            for (int i = 0; i < EXT_MAP_LEN; i++) begin
                if (EXT_MAP[i].code == ev_code) begin
                    hit = 1'b1;
                    idx = EXT_MAP[i].idx;
                end
            end
        end else begin
            for (int i = 0; i < STD_MAP_LEN; i++) begin
                if (STD_MAP[i].code == ev_code) begin
                    hit = 1'b1;
                    idx = STD_MAP[i].idx;
                end
            end
        end
    end

    always_comb begin
        btn_d = btn_q;
        unk_d = 1'b0;
        if (ev_release) begin
            btn_d[15:4] = '1;
        end else if (ev_make || ev_break) begin
            if (hit) begin
                // Active-low: make drives the bit to 0, break back to 1.
                btn_d[idx] = ev_break;
            end else begin
                unk_d = 1'b1;
            end
        end
        upd_d = (btn_d != btn_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_q <= BTN_RESET;
            upd_q <= 1'b0;
            unk_q <= 1'b0;
        end else begin
            btn_q <= btn_d;
            upd_q <= upd_d;
            unk_q <= unk_d;
        end
    end

    assign buttons_n   = btn_q;
    assign update      = upd_q;
    assign unknown_key = unk_q;

endmodule

// File: tb/tb_ps2_snes_key_mapper.sv
// tb/tb_ps2_snes_key_mapper.sv - table-driven self-checking bench for ps2_snes_key_mapper
module tb_ps2_snes_key_mapper;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        byte_valid = 1'b0;
    logic [7:0]  key_byte = 8'h00;
    logic [15:0] buttons_n;
    logic        update;
    logic        unknown_key;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [7:0]  b;
        logic [15:0] btn;
        logic        upd;
        logic        unk;
    } vec_t;

    vec_t vecs[$];

    ps2_snes_key_mapper #(
        .BIT_REVERSE    (0),
        .TIMEOUT_CYCLES (TO),
        .UNUSED_LEVEL   (1'b1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .byte_valid  (byte_valid),
        .key_byte    (key_byte),
        .buttons_n   (buttons_n),
        .update      (update),
        .unknown_key (unknown_key)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] eb, input logic eu, input logic ek);
        n_checks += 3;
        if (buttons_n === eb) n_pass++;
        else $display("FAIL %s buttons_n got %h want %h", name, buttons_n, eb);
        if (update === eu) n_pass++;
        else $display("FAIL %s update got %b want %b", name, update, eu);
        if (unknown_key === ek) n_pass++;
        else $display("FAIL %s unknown_key got %b want %b", name, unknown_key, ek);
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        byte_valid = 1'b1;
        key_byte   = b;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [7:0] b, input logic [15:0] btn, input logic upd, input logic unk);
        vec_t v;
        v.b = b; v.btn = btn; v.upd = upd; v.unk = unk;
        vecs.push_back(v);
    endtask

    initial begin
        add(8'h1D, 16'hF7FF, 1, 0);
        add(8'h1D, 16'hF7FF, 0, 0);
        add(8'h23, 16'hF6FF, 1, 0);
        add(8'hF0, 16'hF6FF, 0, 0);
        add(8'h1D, 16'hFEFF, 1, 0);
        add(8'hF0, 16'hFEFF, 0, 0);
        add(8'h23, 16'hFFFF, 1, 0);
        add(8'h2D, 16'h7FFF, 1, 0);
        add(8'h35, 16'h3FFF, 1, 0);
        add(8'h24, 16'h3F7F, 1, 0);
        add(8'h00, 16'hFFFF, 1, 0);
        add(8'h5A, 16'hFFFF, 0, 1);
        add(8'h2C, 16'hEFFF, 1, 0);
        add(8'h2B, 16'hCFFF, 1, 0);
        add(8'h1B, 16'hCBFF, 1, 0);
        add(8'h1C, 16'hC9FF, 1, 0);
        add(8'h34, 16'hC9BF, 1, 0);
        add(8'h15, 16'hC99F, 1, 0);
        add(8'h3C, 16'hC98F, 1, 0);
        add(8'hF0, 16'hC98F, 0, 0);
        add(8'h00, 16'hFFFF, 1, 0);
        add(8'h2D, 16'h7FFF, 1, 0);
        add(8'hFF, 16'hFFFF, 1, 0);
        add(8'hAA, 16'hFFFF, 0, 0);
        add(8'hF0, 16'hFFFF, 0, 0);
        add(8'h5A, 16'hFFFF, 0, 1);
`ifdef PS2_EXT_KEYS_EN
        add(8'hE0, 16'hFFFF, 0, 0);
        add(8'h75, 16'hF7FF, 1, 0);
        add(8'hE0, 16'hF7FF, 0, 0);
        add(8'hF0, 16'hF7FF, 0, 0);
        add(8'h75, 16'hFFFF, 1, 0);
        add(8'hE0, 16'hFFFF, 0, 0);
        add(8'h1D, 16'hFFFF, 0, 1);
        add(8'hE0, 16'hFFFF, 0, 0);
        add(8'hAA, 16'hFFFF, 0, 0);
        add(8'h75, 16'hFFFF, 0, 1);
`else
        add(8'hE0, 16'hFFFF, 0, 1);
        add(8'h75, 16'hFFFF, 0, 1);
        add(8'h1D, 16'hF7FF, 1, 0);
        add(8'hF0, 16'hF7FF, 0, 0);
        add(8'h1D, 16'hFFFF, 1, 0);
`endif

        #12;
        chk("reset_state", 16'hFFFF, 0, 0);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            send(vecs[i].b);
            chk($sformatf("vec%0d_%h", i, vecs[i].b), vecs[i].btn, vecs[i].upd, vecs[i].unk);
        end

        idle(1);
        chk("pulse_clears", 16'hFFFF, 0, 0);

        send(8'h2D);
        chk("to_setup", 16'h7FFF, 1, 0);
        send(8'hF0);
        idle(TO - 1);
        send(8'h2D);
        chk("to_edge_break_wins", 16'hFFFF, 1, 0);

        send(8'hF0);
        idle(TO);
        send(8'h2D);
        chk("to_expired_make", 16'h7FFF, 1, 0);

        send(8'h00);
        chk("release_before_reset", 16'hFFFF, 1, 0);
        send(8'hF0);
        @(negedge clk);
        reset = 1'b1;
        #2;
        chk("reset_mid_seq", 16'hFFFF, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        send(8'h2D);
        chk("after_reset_make", 16'h7FFF, 1, 0);
        idle(1);
        chk("after_reset_hold", 16'h7FFF, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
